// File: rtl/codificador_sincrono_if.sv
// Bus between the 3-to-8 decoder side, the encoder stage and its consumer.
// Handshake: a word transfers on a rising edge where valid && ready are both high.
interface codificador_sincrono_if #(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int CNT_W = 8
);
    logic [N-1:0]     S;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     code;
    logic             err;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state_dbg;

    modport master (
        output S, in_valid, out_ready,
        input  in_ready, code, err, out_valid, err_count, state_dbg
    );

    modport slave (
        input  S, in_valid, out_ready,
        output in_ready, code, err, out_valid, err_count, state_dbg
    );
endinterface

// File: rtl/codificador_sincrono.sv
// Registered 8-to-3 one-hot encoder with one-hot checking, a 2-entry FIFO
// and a saturating count of malformed words.
module codificador_sincrono #(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    codificador_sincrono_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state, state_next;
    logic             wr_ptr, rd_ptr;
    logic [W:0]       mem [2];
    logic [CNT_W-1:0] err_count_q;
    logic [W-1:0]     enc_code;
    logic             enc_err;
    logic             push, pop;

    // Descending scan so the lowest set index wins when several bits are set.
    always_comb begin
        int ones;
        enc_code = '0;
        ones     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.S[i]) begin
                enc_code = W'(i);
                ones     = ones + 1;
            end
        end
        enc_err = (ones != 1);
    end

    assign push = bus.in_valid && (state != FULL);
    assign pop  = bus.out_ready && (state != EMPTY);

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            mem[0]      <= '0;
            mem[1]      <= '0;
            err_count_q <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                mem[wr_ptr] <= {enc_err, enc_code};
                wr_ptr      <= ~wr_ptr;
                if (enc_err && (err_count_q != {CNT_W{1'b1}}))
                    err_count_q <= err_count_q + 1'b1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.code      = mem[rd_ptr][W-1:0];
    assign bus.err       = mem[rd_ptr][W];
    assign bus.err_count = err_count_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_codificador_sincrono.sv
// Randomized and directed bench for codificador_sincrono against a queue model.
module tb_codificador_sincrono;
    localparam int N = 8, W = 3, CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W:0] exp_q[$];
    int         exp_cnt = 0;

    codificador_sincrono_if #(.N(N), .W(W), .CNT_W(CNT_W)) bus ();

    codificador_sincrono #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoding: lowest set bit isolated by s & -s, its log2 is the index.
    function automatic logic [W:0] ref_entry(input logic [N-1:0] s);
        logic [N-1:0] low;
        int           idx;
        low = s & (~s + 1'b1);
        idx = (s == 0) ? 0 : $clog2(low);
        return {($countones(s) != 1), W'(idx)};
    endfunction

    task automatic check_outputs();
        check("out_valid", bus.out_valid, exp_q.size() != 0);
        check("in_ready", bus.in_ready, exp_q.size() < 2);
        check("occupancy", bus.state_dbg, exp_q.size());
        check("err_count", bus.err_count, exp_cnt);
        if (exp_q.size() != 0) begin
            check("code", bus.code, exp_q[0][W-1:0]);
            check("err", bus.err, exp_q[0][W]);
        end
    endtask

    task automatic cycle(input logic [N-1:0] s, input logic iv, input logic ordy);
        bit do_push, do_pop;
        @(negedge clk);
        check_outputs();
        bus.S = s;
        bus.in_valid = iv;
        bus.out_ready = ordy;
        @(posedge clk);
        do_push = iv && (exp_q.size() < 2);
        do_pop  = ordy && (exp_q.size() != 0);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
            logic [W:0] e;
            e = ref_entry(s);
            exp_q.push_back(e);
            if (e[W] && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        bus.S = 8'h00;
        repeat (cycles) @(posedge clk);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_code", bus.code, 0);
        check("rst_err", bus.err, 1'b0);
        check("rst_err_count", bus.err_count, 0);
    endtask

    initial begin
        bus.S = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        do_reset(2);

        for (int i = 0; i < N; i++) cycle(N'(1) << i, 1'b1, 1'b1);
        cycle('0, 1'b0, 1'b1);

        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'b00010100, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);

        cycle(8'b00100000, 1'b1, 1'b0);
        cycle(8'b01000000, 1'b1, 1'b0);
        repeat (3) cycle(8'b10000000, 1'b1, 1'b0);
        repeat (4) cycle(8'b10000000, 1'b1, 1'b1);
        cycle('0, 1'b0, 1'b1);

        cycle(8'b00000010, 1'b1, 1'b0);
        cycle(8'b00001000, 1'b1, 1'b1);
        cycle(8'b00010000, 1'b1, 1'b1);
        cycle(8'b11000000, 1'b1, 1'b1);
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] s;
            if ($urandom_range(0, 3) == 0) s = N'($urandom);
            else s = N'(1) << $urandom_range(0, N - 1);
            cycle(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (3) cycle('0, 1'b0, 1'b1);

        repeat (260) cycle(8'h00, 1'b1, 1'b1);
        repeat (2) cycle('0, 1'b0, 1'b1);
        check("sat_err_count", bus.err_count, 255);

        do_reset(1);
        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'b00000011, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0);
        check("pre_rst_count", bus.err_count, 3);
        check("pre_rst_full", bus.in_ready, 1'b0);
        do_reset(1);
        repeat (4) cycle('0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
